// File: rtl/writeback_regfile_if.sv
// Execute-to-writeback register bundle (the EX_WB fields consumed by writeback).
// alu_result_ready qualifies the bundle each cycle; there is no ready/backpressure return path.
interface writeback_regfile_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] alu_result;
  logic            alu_result_ready;
  logic [4:0]      reg_wr_addr;
  logic            rd_wr_en;
  logic            do_not_execute;

  modport master (
    output alu_result,
    output alu_result_ready,
    output reg_wr_addr,
    output rd_wr_en,
    output do_not_execute
  );

  modport slave (
    input alu_result,
    input alu_result_ready,
    input reg_wr_addr,
    input rd_wr_en,
    input do_not_execute
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: commits EX_WB results to the 32-entry register file, counts retires, emits a commit trace.
// Optional macro WB_READ_BYPASS_EN: read ports forward the same-cycle write data (write-through).
module writeback_regfile #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  writeback_regfile_if.slave   ex_wb_r,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic [INSTRET_W-1:0] instret,
  output logic                 commit_valid,
  output logic [4:0]           commit_addr,
  output logic [XLEN-1:0]      commit_data
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  logic                 retire;
  logic                 wr_fire;
  logic [XLEN-1:0]      regs_q [32];
  logic [INSTRET_W-1:0] instret_q;
  logic [INSTRET_W-1:0] instret_d;
  logic                 commit_valid_q;
  logic [4:0]           commit_addr_q;
  logic [XLEN-1:0]      commit_data_q;

  assign retire  = ex_wb_r.alu_result_ready & ~ex_wb_r.do_not_execute;
  assign wr_fire = retire & ex_wb_r.rd_wr_en & (ex_wb_r.reg_wr_addr != 5'd0);

  // Counter wraps naturally modulo 2^INSTRET_W.
  assign instret_d = retire ? (instret_q + INSTRET_ONE) : instret_q;

  // Entry 0 is cleared on reset and never written; reads of x0 are forced to zero anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      instret_q      <= '0;
      commit_valid_q <= 1'b0;
      commit_addr_q  <= 5'd0;
      commit_data_q  <= '0;
    end else begin
      if (wr_fire) begin
        regs_q[ex_wb_r.reg_wr_addr] <= ex_wb_r.alu_result;
        commit_addr_q               <= ex_wb_r.reg_wr_addr;
        commit_data_q               <= ex_wb_r.alu_result;
      end
      instret_q      <= instret_d;
      commit_valid_q <= wr_fire;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = regs_q[rs1_addr];
`ifdef WB_READ_BYPASS_EN
      if (wr_fire && (rs1_addr == ex_wb_r.reg_wr_addr)) begin
        rs1_data = ex_wb_r.alu_result;
      end
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = regs_q[rs2_addr];
`ifdef WB_READ_BYPASS_EN
      if (wr_fire && (rs2_addr == ex_wb_r.reg_wr_addr)) begin
        rs2_data = ex_wb_r.alu_result;
      end
`endif
    end
  end

  assign instret      = instret_q;
  assign commit_valid = commit_valid_q;
  assign commit_addr  = commit_addr_q;
  assign commit_data  = commit_data_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: array/queue reference model compared every cycle,
// plus directed literal expectations; a 3-bit instret instance exercises counter wrap.
module tb_writeback_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [63:0] instret;
  logic        commit_valid;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;

  logic [31:0] s_rs1_data;
  logic [31:0] s_rs2_data;
  logic [2:0]  s_instret;
  logic        s_commit_valid;
  logic [4:0]  s_commit_addr;
  logic [31:0] s_commit_data;

  int checks;
  int errors;
  bit chk_en;

  writeback_regfile_if #(.XLEN(32)) ex_if ();

  writeback_regfile #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_wb_r      (ex_if),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .instret      (instret),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_data  (commit_data)
  );

  writeback_regfile #(.XLEN(32), .INSTRET_W(3)) dut_w3 (
    .clk          (clk),
    .reset        (reset),
    .ex_wb_r      (ex_if),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (s_rs1_data),
    .rs2_data     (s_rs2_data),
    .instret      (s_instret),
    .commit_valid (s_commit_valid),
    .commit_addr  (s_commit_addr),
    .commit_data  (s_commit_data)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  logic [4:0]  m_ca;
  logic [31:0] m_cd;
  logic [36:0] exp_q [$];

  function automatic bit m_retire();
    return ex_if.alu_result_ready && !ex_if.do_not_execute;
  endfunction

  function automatic bit m_write();
    return m_retire() && ex_if.rd_wr_en && (ex_if.reg_wr_addr != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_READ_BYPASS_EN
    if (m_write() && (a == ex_if.reg_wr_addr)) return ex_if.alu_result;
`endif
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_instret <= 64'd0;
      m_ca      <= 5'd0;
      m_cd      <= 32'd0;
      exp_q.delete();
    end else begin
      if (m_retire()) m_instret <= m_instret + 64'd1;
      if (m_write()) begin
        m_regs[ex_if.reg_wr_addr] <= ex_if.alu_result;
        m_ca <= ex_if.reg_wr_addr;
        m_cd <= ex_if.alu_result;
        exp_q.push_back({ex_if.reg_wr_addr, ex_if.alu_result});
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("rs1_data", 64'(rs1_data), 64'(exp_read(rs1_addr)));
      check("rs2_data", 64'(rs2_data), 64'(exp_read(rs2_addr)));
      check("instret", instret, m_instret);
      check("w3_instret", 64'(s_instret), 64'(m_instret[2:0]));
      check("w3_rs1_data", 64'(s_rs1_data), 64'(exp_read(rs1_addr)));
      check("w3_rs2_data", 64'(s_rs2_data), 64'(exp_read(rs2_addr)));
      check("commit_valid", 64'(commit_valid), 64'(exp_q.size() != 0));
      check("w3_commit_valid", 64'(s_commit_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("commit_addr_q", 64'(commit_addr), 64'(exp_q[0][36:32]));
        check("commit_data_q", 64'(commit_data), 64'(exp_q[0][31:0]));
        void'(exp_q.pop_front());
      end
      check("commit_addr_hold", 64'(commit_addr), 64'(m_ca));
      check("commit_data_hold", 64'(commit_data), 64'(m_cd));
      check("w3_commit_addr", 64'(s_commit_addr), 64'(m_ca));
      check("w3_commit_data", 64'(s_commit_data), 64'(m_cd));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit rdy, input bit we, input logic [4:0] addr,
                        input logic [31:0] data, input bit dne,
                        input logic [4:0] ra, input logic [4:0] rb);
    ex_if.alu_result_ready = rdy;
    ex_if.rd_wr_en         = we;
    ex_if.reg_wr_addr      = addr;
    ex_if.alu_result       = data;
    ex_if.do_not_execute   = dne;
    rs1_addr               = ra;
    rs2_addr               = rb;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, ra, rb);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    idle(5'd0, 5'd0);
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    #1;
    check("lit_reset_instret", instret, 64'd0);
    check("lit_reset_cvalid", 64'(commit_valid), 64'd0);

    // Reset clears a previously written register.
    set_in(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
    tick();
    idle(5'd5, 5'd0);
    #1;
    check("lit_x5_written", 64'(rs1_data), 64'h0000_0000_DEAD_BEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("lit_x5_after_reset", 64'(rs1_data), 64'd0);
    check("lit_instret_after_reset", instret, 64'd0);
    check("lit_cvalid_after_reset", 64'(commit_valid), 64'd0);

    // Basic write.
    set_in(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7);
    tick();
    idle(5'd0, 5'd7);
    #1;
    check("lit_x7_read", 64'(rs2_data), 64'h0000_0000_1234_5678);
    check("lit_x7_cvalid", 64'(commit_valid), 64'd1);
    check("lit_x7_caddr", 64'(commit_addr), 64'd7);
    check("lit_x7_cdata", 64'(commit_data), 64'h0000_0000_1234_5678);
    check("lit_x7_instret", instret, 64'd1);

    // x0 write: counted, not written, no commit.
    set_in(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd0);
    #1;
    check("lit_x0_read", 64'(rs1_data), 64'd0);
    check("lit_x0_cvalid", 64'(commit_valid), 64'd0);
    check("lit_x0_instret", instret, 64'd2);
    check("lit_x0_caddr_hold", 64'(commit_addr), 64'd7);

    // Squashed instruction.
    set_in(1'b1, 1'b1, 5'd3, 32'hAAAA5555, 1'b1, 5'd3, 5'd0);
    tick();
    idle(5'd3, 5'd0);
    #1;
    check("lit_squash_x3", 64'(rs1_data), 64'd0);
    check("lit_squash_instret", instret, 64'd2);

    // Not ready: nothing happens.
    set_in(1'b0, 1'b1, 5'd3, 32'h0BAD0BAD, 1'b0, 5'd3, 5'd0);
    tick();
    idle(5'd3, 5'd0);
    #1;
    check("lit_idle_x3", 64'(rs1_data), 64'd0);
    check("lit_idle_instret", instret, 64'd2);

    // Retire without register write.
    set_in(1'b1, 1'b0, 5'd6, 32'h66666666, 1'b0, 5'd6, 5'd0);
    tick();
    idle(5'd6, 5'd0);
    #1;
    check("lit_nowr_x6", 64'(rs1_data), 64'd0);
    check("lit_nowr_instret", instret, 64'd3);

    // Same-cycle read of a register being written.
    set_in(1'b1, 1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd9, 5'd9);
    #1;
`ifdef WB_READ_BYPASS_EN
    check("lit_byp_rs1", 64'(rs1_data), 64'h0000_0000_CAFE_F00D);
    check("lit_byp_rs2", 64'(rs2_data), 64'h0000_0000_CAFE_F00D);
`else
    check("lit_byp_rs1", 64'(rs1_data), 64'h0000_0000_1111_1111);
    check("lit_byp_rs2", 64'(rs2_data), 64'h0000_0000_1111_1111);
`endif
    tick();
    idle(5'd9, 5'd9);
    #1;
    check("lit_post_rs1", 64'(rs1_data), 64'h0000_0000_CAFE_F00D);
    check("lit_post_rs2", 64'(rs2_data), 64'h0000_0000_CAFE_F00D);
    check("lit_post_instret", instret, 64'd5);

    // Back-to-back writes to the same register: last wins, two commits.
    set_in(1'b1, 1'b1, 5'd10, 32'h00000001, 1'b0, 5'd10, 5'd10);
    tick();
    set_in(1'b1, 1'b1, 5'd10, 32'h00000002, 1'b0, 5'd10, 5'd10);
    #1;
    check("lit_b2b_cdata1", 64'(commit_data), 64'd1);
    tick();
    idle(5'd10, 5'd10);
    #1;
    check("lit_b2b_x10", 64'(rs1_data), 64'd2);
    check("lit_b2b_cdata2", 64'(commit_data), 64'd2);
    check("lit_b2b_instret", instret, 64'd7);

    // Mixed traffic, model-checked every cycle.
    for (int i = 0; i < 40; i++) begin
      set_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 4) == 0,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    // Counter wrap on the 3-bit instance.
    reset = 1'b1;
    idle(5'd0, 5'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 5'd0, 5'd0);
      tick();
    end
    #1;
    check("lit_w3_seven", 64'(s_instret), 64'd7);
    tick();
    idle(5'd0, 5'd0);
    #1;
    check("lit_w3_wrap", 64'(s_instret), 64'd0);
    check("lit_w64_eight", instret, 64'd8);

    // Reset takes priority over a simultaneous write.
    set_in(1'b1, 1'b1, 5'd4, 32'h44444444, 1'b0, 5'd4, 5'd0);
    tick();
    reset = 1'b1;
    set_in(1'b1, 1'b1, 5'd4, 32'h55555555, 1'b0, 5'd4, 5'd0);
    tick();
    reset = 1'b0;
    idle(5'd4, 5'd0);
    #1;
    check("lit_rstprio_x4", 64'(rs1_data), 64'd0);
    check("lit_rstprio_cvalid", 64'(commit_valid), 64'd0);
    check("lit_rstprio_instret", instret, 64'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
